// File: rtl/tick_display_pkg.sv
// tick_display_pkg: segment patterns, digit slots and decode helper shared by tick_display.
package tick_display_pkg;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int DIG_MODE     = 7;
  localparam int DIG_CNT2_MSD = 6;
  localparam int DIG_CNT1_MSD = 3;
  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    return v == 4'd0 ? SEG_0 :
           v == 4'd1 ? SEG_1 :
           v == 4'd2 ? SEG_2 :
           v == 4'd3 ? SEG_3 :
           v == 4'd4 ? SEG_4 :
           v == 4'd5 ? SEG_5 :
           v == 4'd6 ? SEG_6 :
           v == 4'd7 ? SEG_7 :
           v == 4'd8 ? SEG_8 :
           v == 4'd9 ? SEG_9 : SEG_BLANK;
  endfunction
endpackage

// File: rtl/tick_display_sync_edge.sv
// sync_edge: two-flop synchroniser followed by a one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic tick
);
  logic s1, s2, prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1, s2, prev} <= 3'b000;
    else      {s1, s2, prev} <= {d, s1, s2};
  assign tick = s2 & ~prev;
endmodule

// File: rtl/tick_display.sv
// tick_display: BCD edge counters for clk_1/clk_2 plus prog_out on a multiplexed 8-digit 7-segment display.
// Optional leading-zero blanking with TICK_DISPLAY_ZERO_BLANK_EN.
module tick_display
  import tick_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT1_DIGITS = 4,
  parameter int CNT2_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1,
  input  logic       clk_2,
  input  logic [2:0] prog_out,
  input  logic       hold,
  output logic [7:0] an,
  output logic [7:0] seg
);
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_CNT2_LSD = DIG_CNT1_MSD + 1;
  logic tick1, tick2;
  logic [CNT1_DIGITS-1:0][3:0] cnt1, cnt1_inc, cnt1_nx;
  logic [CNT2_DIGITS-1:0][3:0] cnt2, cnt2_inc, cnt2_nx;
  logic [2:0] prev_mode;
  logic mode_ok, mode_chg;
  logic [RW-1:0] ref_cnt;
  logic [2:0] dig, dig_nx;
  logic live, live_nx, term;
  logic [7:0][3:0] disp;
  logic [7:0] blank, seg_v;

  sync_edge u_sync1 (.clk(clk), .rst(rst), .d(clk_1), .tick(tick1));
  sync_edge u_sync2 (.clk(clk), .rst(rst), .d(clk_2), .tick(tick2));

  always_comb begin
    logic cy;
    cy = 1'b1;
    cnt1_inc = cnt1;
    for (int i = 0; i < CNT1_DIGITS; i++) begin
      cnt1_inc[i] = cy ? (cnt1[i] == 4'd9 ? 4'd0 : cnt1[i] + 4'd1) : cnt1[i];
      cy = cy & (cnt1[i] == 4'd9);
    end
  end

  always_comb begin
    logic cy;
    cy = 1'b1;
    cnt2_inc = cnt2;
    for (int i = 0; i < CNT2_DIGITS; i++) begin
      cnt2_inc[i] = cy ? (cnt2[i] == 4'd9 ? 4'd0 : cnt2[i] + 4'd1) : cnt2[i];
      cy = cy & (cnt2[i] == 4'd9);
    end
  end

  // prev_mode is only trusted once it has captured prog_out after reset
  assign mode_chg = mode_ok && prog_out != prev_mode;
  assign cnt1_nx  = (tick1 && !hold) ? cnt1_inc : cnt1;
  assign cnt2_nx  = mode_chg ? '0 : (tick2 && !hold) ? cnt2_inc : cnt2;
  assign term     = ref_cnt == RW'(REFRESH_DIV - 1);
  assign live_nx  = live | term;
  assign dig_nx   = (term && live) ? dig + 3'd1 : dig;

  always_comb begin
    disp = '0;
    blank = '0;
    disp[DIG_MODE] = {1'b0, prog_out};
    for (int i = 0; i < CNT2_DIGITS; i++) disp[DIG_CNT2_LSD + i] = cnt2_nx[i];
    for (int i = 0; i < CNT1_DIGITS; i++) disp[i] = cnt1_nx[i];
`ifdef TICK_DISPLAY_ZERO_BLANK_EN
    begin
      logic z;
      z = 1'b1;
      for (int i = CNT2_DIGITS - 1; i > 0; i--) begin
        z = z & (cnt2_nx[i] == 4'd0);
        blank[DIG_CNT2_LSD + i] = z;
      end
      z = 1'b1;
      for (int i = CNT1_DIGITS - 1; i > 0; i--) begin
        z = z & (cnt1_nx[i] == 4'd0);
        blank[i] = z;
      end
    end
`endif
    seg_v = blank[dig_nx] ? SEG_BLANK : seg_decode(disp[dig_nx]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt1      <= '0;
      cnt2      <= '0;
      prev_mode <= 3'd0;
      mode_ok   <= 1'b0;
      ref_cnt   <= '0;
      dig       <= 3'd0;
      live      <= 1'b0;
      an        <= 8'hFF;
      seg       <= 8'hFF;
    end else begin
      cnt1      <= cnt1_nx;
      cnt2      <= cnt2_nx;
      prev_mode <= prog_out;
      mode_ok   <= 1'b1;
      ref_cnt   <= term ? '0 : ref_cnt + RW'(1);
      dig       <= dig_nx;
      live      <= live_nx;
      an        <= live_nx ? ~(8'd1 << dig_nx) : 8'hFF;
      seg       <= live_nx ? {dig_nx != 3'(DIG_CNT2_LSD), seg_v[6:0]} : 8'hFF;
    end
  end
endmodule

// File: tb/tb_tick_display.sv
// tb_tick_display: arithmetic reference model of counts and scan position, checked every cycle, plus literal spot checks.
module tb_tick_display;
  localparam int RD = 4;
`ifdef TICK_DISPLAY_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif
  logic clk = 0, rst = 0, clk_1 = 0, clk_2 = 0, hold = 0;
  logic [2:0] prog_out = 3'd3;
  logic [7:0] an, seg;
  int n_tests = 0, n_fail = 0;
  int m_c1, m_c2, m_cyc;
  logic [2:0] m_prev, m_mode, h1, h2;
  logic m_init;

  tick_display #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .clk_1(clk_1), .clk_2(clk_2),
    .prog_out(prog_out), .hold(hold), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dec(input int v);
    logic [7:0] tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return (v >= 0 && v < 10) ? tab[v] : 8'hFF;
  endfunction

  function automatic int p10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // a rise counts when the sample two edges back is 1 and the one three edges back is 0
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_c1 <= 0; m_c2 <= 0; m_cyc <= 0; m_init <= 0;
      m_prev <= 0; m_mode <= 0; h1 <= 0; h2 <= 0;
    end else begin
      m_cyc  <= m_cyc + 1;
      h1     <= {h1[1:0], clk_1};
      h2     <= {h2[1:0], clk_2};
      m_mode <= prog_out;
      m_prev <= prog_out;
      m_init <= 1;
      if (h1[1] && !h1[2] && !hold) m_c1 <= (m_c1 + 1) % 10000;
      if (m_init && prog_out != m_prev) m_c2 <= 0;
      else if (h2[1] && !h2[2] && !hold) m_c2 <= (m_c2 + 1) % 1000;
    end
  end

  function automatic logic [15:0] expect_out();
    int d, cnt, pos;
    logic [7:0] s;
    if (m_cyc < RD) return 16'hFFFF;
    d = (m_cyc / RD - 1) % 8;
    if (d == 7) s = dec(int'(m_mode));
    else begin
      cnt = d >= 4 ? m_c2 : m_c1;
      pos = d >= 4 ? d - 4 : d;
      s = dec((cnt / p10(pos)) % 10);
`ifdef TICK_DISPLAY_ZERO_BLANK_EN
      if (pos > 0 && cnt < p10(pos)) s = 8'hFF;
`endif
      if (d == 4) s[7] = 1'b0;
    end
    return {~8'(1 << d), s};
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: an/seg got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("model", {an, seg}, expect_out());
  end

  task automatic see(input int d, input logic [7:0] exp, input string nm);
    int k = 0;
    while (an !== ~8'(1 << d) && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {an, seg}, {~8'(1 << d), exp});
  endtask

  task automatic pulse1(input int n);
    repeat (n) begin
      @(negedge clk); clk_1 = 1;
      @(negedge clk); clk_1 = 0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse2(input int n);
    repeat (n) begin
      @(negedge clk); clk_2 = 1;
      @(negedge clk); clk_2 = 0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("in_reset", {an, seg}, 16'hFFFF);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("pre_scan", {an, seg}, 16'hFFFF);
    @(negedge clk);
    chk("first_digit", {an, seg}, {8'hFE, 8'hC0});
    clk_1 = 1;
    repeat (2) @(negedge clk);
    chk("lat_edge2", {an, seg}, {8'hFE, 8'hC0});
    @(negedge clk);
    chk("lat_edge3", {an, seg}, {8'hFE, 8'hF9});
    clk_1 = 0;
    see(1, LZ, "one_d1");
    see(3, LZ, "one_d3");
    see(7, 8'hB0, "mode3");
    pulse1(9999);
    see(0, 8'hC0, "wrap1_d0");
    see(3, LZ, "wrap1_d3");
    hold = 1;
    pulse1(5);
    hold = 0;
    see(0, 8'hC0, "hold_d0");
    pulse1(2);
    see(0, 8'hA4, "unhold_d0");
    pulse1(40);
    see(3, LZ, "c42_d3");
    see(2, LZ, "c42_d2");
    see(1, 8'h99, "c42_d1");
    see(0, 8'hA4, "c42_d0");
    pulse2(37);
    see(5, 8'hB0, "c37_d5");
    see(4, 8'h78, "c37_d4");
    @(negedge clk); clk_2 = 1;
    @(negedge clk);
    @(negedge clk); prog_out = 3'd5;
    @(negedge clk); clk_2 = 0;
    repeat (3) @(negedge clk);
    see(4, 8'h40, "mchg_d4");
    see(5, LZ, "mchg_d5");
    see(7, 8'h92, "mchg_d7");
    pulse2(1000);
    see(6, LZ, "wrap2_d6");
    see(5, LZ, "wrap2_d5");
    see(4, 8'h40, "wrap2_d4");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
